// File: rtl/keypad_entry.sv
// rtl/keypad_entry.sv - debounced keypad front end: PIN digit forwarding and BCD amount entry with conversion
module keypad_entry #(
    parameter int DEBOUNCE   = 4,
    parameter int MAX_DIGITS = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_down_i,
    input  logic [3:0]  key_code_i,
    input  logic        mode_i,
    output logic [3:0]  digito_o,
    output logic        digito_stb_o,
    output logic [31:0] monto_o,
    output logic        monto_stb_o,
    output logic [3:0]  digit_count_o,
    output logic        busy_o,
    output logic        entry_error_o
);
    localparam int         BW        = 4 * MAX_DIGITS;
    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_BACK  = 4'hB;
    localparam logic [3:0] KEY_ENTER = 4'hC;
    localparam logic [3:0] MAX_CNT   = 4'(MAX_DIGITS);
    localparam logic [4:0] DEB_CNT   = 5'(DEBOUNCE);

    typedef enum logic [1:0] {DB_IDLE, DB_CHECK, DB_HELD} db_state_t;
    typedef enum logic {ST_COLLECT, ST_CONVERT} st_t;

    db_state_t       db_state_q, db_state_d;
    logic [3:0]      db_code_q, db_code_d;
    logic [3:0]      db_cnt_q, db_cnt_d;
    logic            accept;

    st_t             st_q, st_d;
    logic [BW-1:0]   buf_q, buf_d;
    logic [3:0]      count_q, count_d;
    logic [31:0]     acc_q, acc_d;
    logic [3:0]      conv_idx_q, conv_idx_d;
    logic            mode_prev_q;
    logic [3:0]      digito_q, digito_d;
    logic            digito_stb_q, digito_stb_d;
    logic [31:0]     monto_q, monto_d;
    logic            monto_stb_q, monto_stb_d;
    logic            err_q, err_d;
    logic [3:0]      digit_sel;
    logic [31:0]     acc_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            db_state_q   <= DB_IDLE;
            db_code_q    <= '0;
            db_cnt_q     <= '0;
            st_q         <= ST_COLLECT;
            buf_q        <= '0;
            count_q      <= '0;
            acc_q        <= '0;
            conv_idx_q   <= '0;
            mode_prev_q  <= 1'b0;
            digito_q     <= '0;
            digito_stb_q <= 1'b0;
            monto_q      <= '0;
            monto_stb_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            db_state_q   <= db_state_d;
            db_code_q    <= db_code_d;
            db_cnt_q     <= db_cnt_d;
            st_q         <= st_d;
            buf_q        <= buf_d;
            count_q      <= count_d;
            acc_q        <= acc_d;
            conv_idx_q   <= conv_idx_d;
            mode_prev_q  <= mode_i;
            digito_q     <= digito_d;
            digito_stb_q <= digito_stb_d;
            monto_q      <= monto_d;
            monto_stb_q  <= monto_stb_d;
            err_q        <= err_d;
        end
    end

    // accept is combinational so the consequences land on the same edge as the DEBOUNCE-th sample
    always_comb begin
        db_state_d = db_state_q;
        db_code_d  = db_code_q;
        db_cnt_d   = db_cnt_q;
        accept     = 1'b0;
        case (db_state_q)
            DB_IDLE: begin
                if (key_down_i) begin
                    db_code_d = key_code_i;
                    db_cnt_d  = 4'd1;
                    if (DEBOUNCE == 1) begin
                        accept     = 1'b1;
                        db_state_d = DB_HELD;
                    end else begin
                        db_state_d = DB_CHECK;
                    end
                end
            end
            DB_CHECK: begin
                if (!key_down_i) begin
                    db_state_d = DB_IDLE;
                end else if (key_code_i != db_code_q) begin
                    db_code_d = key_code_i;
                    db_cnt_d  = 4'd1;
                end else if ({1'b0, db_cnt_q} + 5'd1 == DEB_CNT) begin
                    accept     = 1'b1;
                    db_state_d = DB_HELD;
                end else begin
                    db_cnt_d = db_cnt_q + 4'd1;
                end
            end
            default: begin
                if (!key_down_i) db_state_d = DB_IDLE;
            end
        endcase
    end

    // conv_idx counts remaining digits; digit at position conv_idx-1 is the next most significant
    always_comb begin
        digit_sel = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (conv_idx_q == 4'(i + 1)) digit_sel = buf_q[4*i +: 4];
        end
        acc_next = acc_q * 32'd10 + {28'd0, digit_sel};
    end

    always_comb begin
        st_d         = st_q;
        buf_d        = buf_q;
        count_d      = count_q;
        acc_d        = acc_q;
        conv_idx_d   = conv_idx_q;
        digito_d     = digito_q;
        digito_stb_d = 1'b0;
        monto_d      = monto_q;
        monto_stb_d  = 1'b0;
        err_d        = 1'b0;
        case (st_q)
            ST_COLLECT: begin
                // clearing first lets a key accepted on the mode-change cycle act on an empty buffer
                if (mode_i != mode_prev_q) begin
                    buf_d   = '0;
                    count_d = '0;
                end
                if (accept) begin
                    if (!mode_i) begin
                        if (key_code_i <= 4'd9) begin
                            digito_d     = key_code_i;
                            digito_stb_d = 1'b1;
                        end
                    end else if (key_code_i <= 4'd9) begin
                        if (count_d == MAX_CNT) begin
                            err_d = 1'b1;
                        end else begin
                            buf_d   = (buf_d << 4) | BW'(key_code_i);
                            count_d = count_d + 4'd1;
                        end
                    end else if (key_code_i == KEY_CLEAR) begin
                        buf_d   = '0;
                        count_d = '0;
                    end else if (key_code_i == KEY_BACK) begin
                        if (count_d != 4'd0) begin
                            buf_d   = buf_d >> 4;
                            count_d = count_d - 4'd1;
                        end
                    end else if (key_code_i == KEY_ENTER) begin
                        if (count_d == 4'd0) begin
                            err_d = 1'b1;
                        end else begin
                            st_d       = ST_CONVERT;
                            acc_d      = '0;
                            conv_idx_d = count_d;
                        end
                    end
                end
            end
            default: begin
                if (accept) err_d = 1'b1;
                if (conv_idx_q == 4'd1) begin
                    monto_d     = acc_next;
                    monto_stb_d = 1'b1;
                    buf_d       = '0;
                    count_d     = '0;
                    st_d        = ST_COLLECT;
                end else begin
                    acc_d      = acc_next;
                    conv_idx_d = conv_idx_q - 4'd1;
                end
            end
        endcase
    end

    assign digito_o      = digito_q;
    assign digito_stb_o  = digito_stb_q;
    assign monto_o       = monto_q;
    assign monto_stb_o   = monto_stb_q;
    assign digit_count_o = count_q;
    assign busy_o        = (st_q == ST_CONVERT);
    assign entry_error_o = err_q;

endmodule

// File: tb/tb_keypad_entry.sv
// tb/tb_keypad_entry.sv - self-checking bench for keypad_entry with a queue-based reference model
module tb_keypad_entry;
    localparam int DEB  = 4;
    localparam int MAXD = 9;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_down;
    logic [3:0]  key_code;
    logic        mode;
    logic [3:0]  digito;
    logic        digito_stb;
    logic [31:0] monto;
    logic        monto_stb;
    logic [3:0]  digit_count;
    logic        busy;
    logic        entry_error;

    always #5 clk = ~clk;

    keypad_entry #(.DEBOUNCE(DEB), .MAX_DIGITS(MAXD)) dut (
        .clk(clk), .rst(rst), .key_down_i(key_down), .key_code_i(key_code), .mode_i(mode),
        .digito_o(digito), .digito_stb_o(digito_stb), .monto_o(monto), .monto_stb_o(monto_stb),
        .digit_count_o(digit_count), .busy_o(busy), .entry_error_o(entry_error)
    );

    int checks = 0;
    int passed = 0;

    // reference model: run-length debounce, digits held as integers MSD first
    int          m_run = 0;
    logic [3:0]  m_code = 4'd0;
    bit          m_held = 0;
    bit          m_mode_prev = 0;
    int          m_digits[$];
    bit          m_conv = 0;
    int          m_left = 0;
    longint      m_val = 0;
    logic [3:0]  e_digito = 4'd0;
    bit          e_dstb = 0, e_mstb = 0, e_err = 0;
    logic [31:0] e_monto = 32'd0;

    bit          cur_mode = 0;
    bit          cur_rst = 1;
    int          cyc = 0;
    int          mism, dstb_n, mstb_n, err_n, busy_n, dstb_cyc;
    logic [3:0]  last_digito;
    logic [31:0] last_monto;
    logic [43:0] bad_dut, bad_exp;

    function automatic logic [43:0] dut_vec();
        return {digito, digito_stb, monto, monto_stb, digit_count, busy, entry_error};
    endfunction

    function automatic logic [43:0] exp_vec();
        return {e_digito, e_dstb, e_monto, e_mstb, 4'(m_digits.size()), m_conv, e_err};
    endfunction

    task automatic model_step(input bit kd, input logic [3:0] kc, input bit md, input bit r);
        bit acc;
        if (r) begin
            m_run = 0; m_held = 0; m_mode_prev = 0; m_digits.delete(); m_conv = 0;
            e_digito = 0; e_dstb = 0; e_monto = 0; e_mstb = 0; e_err = 0;
            return;
        end
        acc = 0;
        if (!kd) begin
            m_run = 0;
            m_held = 0;
        end else if (!m_held) begin
            if (m_run > 0 && kc == m_code) m_run++;
            else begin m_run = 1; m_code = kc; end
            if (m_run == DEB) begin acc = 1; m_held = 1; end
        end
        e_dstb = 0; e_mstb = 0; e_err = 0;
        if (m_conv) begin
            if (acc) e_err = 1;
            m_left--;
            if (m_left == 0) begin
                e_monto = m_val[31:0];
                e_mstb = 1;
                m_digits.delete();
                m_conv = 0;
            end
        end else begin
            if (md != m_mode_prev) m_digits.delete();
            if (acc) begin
                if (!md) begin
                    if (kc <= 9) begin e_digito = kc; e_dstb = 1; end
                end else if (kc <= 9) begin
                    if (m_digits.size() == MAXD) e_err = 1;
                    else m_digits.push_back(int'(kc));
                end else if (kc == 4'hA) begin
                    m_digits.delete();
                end else if (kc == 4'hB) begin
                    if (m_digits.size() > 0) void'(m_digits.pop_back());
                end else if (kc == 4'hC) begin
                    if (m_digits.size() == 0) e_err = 1;
                    else begin
                        m_val = 0;
                        foreach (m_digits[i]) m_val = m_val * 10 + m_digits[i];
                        m_left = m_digits.size();
                        m_conv = 1;
                    end
                end
            end
        end
        m_mode_prev = md;
    endtask

    task automatic tick(input bit kd, input logic [3:0] kc);
        key_down = kd;
        key_code = kc;
        mode = cur_mode;
        rst = cur_rst;
        @(posedge clk);
        model_step(kd, kc, cur_mode, cur_rst);
        #1;
        cyc++;
        if (dut_vec() !== exp_vec()) begin
            if (mism == 0) begin bad_dut = dut_vec(); bad_exp = exp_vec(); end
            mism++;
        end
        if (digito_stb === 1'b1) begin dstb_n++; last_digito = digito; dstb_cyc = cyc; end
        if (monto_stb === 1'b1) begin mstb_n++; last_monto = monto; end
        if (entry_error === 1'b1) err_n++;
        if (busy === 1'b1) busy_n++;
    endtask

    task automatic press(input logic [3:0] c, input int hold, input int gap);
        repeat (hold) tick(1, c);
        repeat (gap) tick(0, c);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(0, 4'd0);
    endtask

    task automatic clear_log();
        mism = 0; dstb_n = 0; mstb_n = 0; err_n = 0; busy_n = 0; dstb_cyc = -1;
        last_digito = 4'd0; last_monto = 32'd0; bad_dut = '0; bad_exp = '0;
    endtask

    task automatic test_reset();
        clear_log();
        cur_rst = 1; cur_mode = 0;
        idle(3);
        checks++;
        if (dut_vec() !== 44'h0) $display("FAIL reset_outputs: got %h expected %h", dut_vec(), 44'h0);
        else passed++;
        cur_rst = 0;
        idle(2);
        checks++;
        if (dut_vec() !== 44'h0) $display("FAIL reset_idle: got %h expected %h", dut_vec(), 44'h0);
        else passed++;
    endtask

    task automatic test_debounce();
        int c0;
        clear_log();
        c0 = cyc;
        press(4'd7, 3, 1);
        press(4'd7, 6, 2);
        checks++;
        if (dstb_n !== 1) $display("FAIL debounce_count: got %0d expected 1", dstb_n); else passed++;
        checks++;
        if (last_digito !== 4'd7) $display("FAIL debounce_digit: got %0d expected 7", last_digito); else passed++;
        checks++;
        if (dstb_cyc !== c0 + 8) $display("FAIL debounce_timing: got cycle %0d expected %0d", dstb_cyc - c0, 8); else passed++;
        checks++;
        if (mism !== 0) $display("FAIL debounce_model: %0d cycles differ, first got %h expected %h", mism, bad_dut, bad_exp); else passed++;
    endtask

    task automatic test_bounce();
        clear_log();
        repeat (2) tick(1, 4'd3);
        repeat (4) tick(1, 4'd5);
        checks++;
        if (dstb_n !== 1 || last_digito !== 4'd5) $display("FAIL bounce_accept: got %0d strobes digit %0d expected 1 strobe digit 5", dstb_n, last_digito); else passed++;
        repeat (20) tick(1, 4'd5);
        idle(2);
        checks++;
        if (dstb_n !== 1) $display("FAIL bounce_hold: got %0d strobes expected 1", dstb_n); else passed++;
        checks++;
        if (mism !== 0) $display("FAIL bounce_model: %0d cycles differ, first got %h expected %h", mism, bad_dut, bad_exp); else passed++;
    endtask

    task automatic test_amount();
        clear_log();
        cur_mode = 1;
        press(4'd4, 4, 1); press(4'd5, 4, 1); press(4'd0, 4, 1); press(4'd0, 4, 1);
        checks++;
        if (digit_count !== 4'd4) $display("FAIL amount_count: got %0d expected 4", digit_count); else passed++;
        press(4'hC, 4, 1);
        idle(8);
        checks++;
        if (mstb_n !== 1 || last_monto !== 32'h1194) $display("FAIL amount_value: got %0d strobes value %0d expected 1 strobe value 4500", mstb_n, last_monto); else passed++;
        checks++;
        if (busy_n !== 4) $display("FAIL amount_busy: got %0d expected 4", busy_n); else passed++;
        checks++;
        if (digit_count !== 4'd0 || err_n !== 0) $display("FAIL amount_after: got count %0d errors %0d expected 0 0", digit_count, err_n); else passed++;
        checks++;
        if (mism !== 0) $display("FAIL amount_model: %0d cycles differ, first got %h expected %h", mism, bad_dut, bad_exp); else passed++;
    endtask

    task automatic test_edit();
        clear_log();
        press(4'd1, 4, 1); press(4'd2, 4, 1); press(4'd3, 4, 1);
        press(4'hB, 4, 1); press(4'd9, 4, 1); press(4'hC, 4, 1);
        idle(8);
        checks++;
        if (mstb_n !== 1 || last_monto !== 32'd129) $display("FAIL edit_back: got %0d strobes value %0d expected 1 strobe value 129", mstb_n, last_monto); else passed++;
        clear_log();
        press(4'd8, 4, 1); press(4'hA, 4, 1); press(4'hC, 4, 1);
        idle(4);
        checks++;
        if (err_n !== 1 || mstb_n !== 0) $display("FAIL edit_clear_enter: got %0d errors %0d strobes expected 1 error 0 strobes", err_n, mstb_n); else passed++;
        checks++;
        if (mism !== 0) $display("FAIL edit_model: %0d cycles differ, first got %h expected %h", mism, bad_dut, bad_exp); else passed++;
    endtask

    task automatic test_overflow();
        clear_log();
        repeat (10) press(4'd9, 4, 1);
        checks++;
        if (digit_count !== 4'd9 || err_n !== 1) $display("FAIL overflow_full: got count %0d errors %0d expected 9 1", digit_count, err_n); else passed++;
        press(4'hC, 4, 1);
        press(4'd1, 4, 1);
        idle(10);
        checks++;
        if (last_monto !== 32'd999999999 || mstb_n !== 1) $display("FAIL overflow_value: got %0d (%0d strobes) expected 999999999", last_monto, mstb_n); else passed++;
        checks++;
        if (busy_n !== 9) $display("FAIL overflow_busy: got %0d expected 9", busy_n); else passed++;
        checks++;
        if (err_n !== 2 || digit_count !== 4'd0) $display("FAIL overflow_key_in_convert: got errors %0d count %0d expected 2 0", err_n, digit_count); else passed++;
        checks++;
        if (mism !== 0) $display("FAIL overflow_model: %0d cycles differ, first got %h expected %h", mism, bad_dut, bad_exp); else passed++;
    endtask

    task automatic test_reset_mode();
        clear_log();
        press(4'd1, 4, 1); press(4'd2, 4, 1); press(4'd3, 4, 1);
        press(4'hC, 4, 0);
        tick(0, 4'd0); tick(0, 4'd0);
        checks++;
        if (busy !== 1'b1) $display("FAIL reset_mid_busy: got %b expected 1", busy); else passed++;
        cur_rst = 1;
        tick(0, 4'd0);
        checks++;
        if (dut_vec() !== 44'h0) $display("FAIL reset_mid_outputs: got %h expected %h", dut_vec(), 44'h0); else passed++;
        cur_rst = 0;
        idle(12);
        checks++;
        if (mstb_n !== 0) $display("FAIL reset_mid_abort: got %0d strobes expected 0", mstb_n); else passed++;
        press(4'd5, 4, 1); press(4'd6, 4, 1);
        checks++;
        if (digit_count !== 4'd2) $display("FAIL mode_two_digits: got %0d expected 2", digit_count); else passed++;
        cur_mode = 0;
        tick(0, 4'd0);
        checks++;
        if (digit_count !== 4'd0) $display("FAIL mode_change_clear: got %0d expected 0", digit_count); else passed++;
        dstb_n = 0; mstb_n = 0;
        press(4'd6, 4, 2);
        checks++;
        if (dstb_n !== 1 || mstb_n !== 0 || last_digito !== 4'd6) $display("FAIL mode_pin_forward: got %0d/%0d strobes digit %0d expected 1/0 digit 6", dstb_n, mstb_n, last_digito); else passed++;
        checks++;
        if (mism !== 0) $display("FAIL reset_mode_model: %0d cycles differ, first got %h expected %h", mism, bad_dut, bad_exp); else passed++;
    endtask

    task automatic test_random();
        int r;
        logic [3:0] c;
        clear_log();
        for (int i = 0; i < 150; i++) begin
            if ($urandom % 8 == 0) cur_mode = ~cur_mode;
            r = $urandom % 20;
            if (r < 12) c = 4'(r % 10);
            else if (r < 15) c = 4'hC;
            else if (r == 15) c = 4'hA;
            else if (r == 16) c = 4'hB;
            else c = 4'(13 + $urandom % 3);
            if ($urandom % 4 == 0) repeat ($urandom_range(1, 3)) tick(1, 4'($urandom % 16));
            press(c, $urandom_range(1, 7), $urandom_range(1, 3));
        end
        idle(12);
        checks++;
        if (mism !== 0) $display("FAIL random_model: %0d cycles differ, first got %h expected %h", mism, bad_dut, bad_exp); else passed++;
        checks++;
        if (dstb_n + mstb_n == 0) $display("FAIL random_activity: got 0 strobes expected some"); else passed++;
    endtask

    initial begin
        rst = 1'b1; key_down = 1'b0; key_code = 4'd0; mode = 1'b0;
        test_reset();
        test_debounce();
        test_bounce();
        test_amount();
        test_edit();
        test_overflow();
        test_reset_mode();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
